rate_down_counter: RTL and testbench



---
 rtl/lab_timing_pkg.sv | 26 ++
 rtl/rate_divider.sv | 71 +++++++
 rtl/rate_down_counter.sv | 75 +++++++
 tb/tb_rate_down_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lab_timing_pkg.sv
// Purpose: shared rate-select encodings and period lookup for the lab timing blocks.
// Latency: n/a (package: types and a pure function only).
// Backpressure: n/a.
package lab_timing_pkg;

    typedef enum logic [1:0] {
        SPEED_FULL    = 2'b00,
        SPEED_1HZ     = 2'b01,
        SPEED_HALF    = 2'b10,
        SPEED_QUARTER = 2'b11
    } speed_e;

    // Number of Clock cycles between Ticks for a given rate select.
    function automatic int unsigned rate_period(input logic [1:0] speed,
                                                input int unsigned clock_frequency);
        int unsigned period;
        case (speed)
            SPEED_FULL:    period = 1;
            SPEED_1HZ:     period = clock_frequency;
            SPEED_HALF:    period = 2 * clock_frequency;
            default:       period = 4 * clock_frequency;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Purpose: programmable divider turning Clock into a one-cycle Tick every P(Speed) cycles.
// Latency: Tick is combinational from the current rate count; first Tick P cycles after reset.
// Backpressure: none; Enable low freezes the count, Restart reloads it and masks Tick.
//
// Ports:
//   Clock   - system clock, posedge
//   Reset   - asynchronous, active-high
//   Enable  - divider advances only while high
//   Speed   - rate select (see lab_timing_pkg)
//   Restart - reload the period from the top and suppress Tick this cycle
//   Tick    - one-cycle strobe when the count reaches zero
module rate_divider
    import lab_timing_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Speed,
    input  logic       Restart,
    output logic       Tick
);

    localparam int unsigned RW = $clog2(4 * CLOCK_FREQUENCY);

    logic [RW-1:0] rate_count;
    logic [RW-1:0] reload_value;
    logic [RW-1:0] current_count;
    logic          fresh;

    always_comb begin
        reload_value = RW'(rate_period(Speed, CLOCK_FREQUENCY) - 1);
    end

    // While in reset (and until the first edge after release) the effective
    // count follows P(Speed)-1 live, so the register itself can use a constant
    // reset value instead of an asynchronous load of a data-dependent value.
    always_comb begin
        current_count = fresh ? reload_value : rate_count;
    end

    // Reset gating keeps Tick low during reset even at SPEED_FULL, where the
    // reload value is already zero.
    always_comb begin
        Tick = Enable & ~Restart & ~Reset & (current_count == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rate_count <= '0;
            fresh      <= 1'b1;
        end else begin
            fresh <= 1'b0;
            if (Restart) begin
                rate_count <= reload_value;
            end else if (Enable) begin
                // Speed is only sampled on reload, so a rate change lets the
                // current period run out at the old rate.
                if (current_count == '0) begin
                    rate_count <= reload_value;
                end else begin
                    rate_count <= current_count - RW'(1);
                end
            end else begin
                rate_count <= current_count;
            end
        end
    end

endmodule

// File: rtl/rate_down_counter.sv
// Purpose: rate-divided Tick source plus a loadable down counter that consumes the same Ticks.
// Latency: Tick combinational; CounterValue/Done update on the posedge that sees Tick or Load.
// Backpressure: none; Load wins over Tick in the same cycle and restarts the rate period.
//
// Ports:
//   Clock, Reset         - posedge clock, asynchronous active-high reset
//   Enable, Speed        - divider run control and rate select
//   Load, LoadValue      - synchronous load of the down count and its stored start value
//   Wrap                 - at zero: 1 reloads the start value, 0 holds at zero
//   Tick                 - divided strobe, usable as a downstream counter Enable
//   CounterValue, Done   - current count and registered (CounterValue == 0) flag
module rate_down_counter
    import lab_timing_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned WIDTH           = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [1:0]       Speed,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Wrap,
    output logic             Tick,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Done
);

    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] count_next;

    rate_divider #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY)
    ) u_rate_divider (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Speed   (Speed),
        .Restart (Load),
        .Tick    (Tick)
    );

    // Tick is already masked by Load inside the divider; Load is still
    // checked first so the load path does not depend on that masking.
    always_comb begin
        count_next = CounterValue;
        if (Load) begin
            count_next = LoadValue;
        end else if (Tick) begin
            if (CounterValue != '0) begin
                count_next = CounterValue - WIDTH'(1);
            end else if (Wrap) begin
                count_next = start_value;
            end
        end
    end

    // Done is registered from the next count, so it always matches
    // CounterValue in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            CounterValue <= '1;
            start_value  <= '1;
            Done         <= 1'b0;
        end else begin
            CounterValue <= count_next;
            Done         <= (count_next == '0);
            if (Load) begin
                start_value <= LoadValue;
            end
        end
    end

endmodule

// File: tb/tb_rate_down_counter.sv
module tb_rate_down_counter;

    localparam int CF = 4;
    localparam int W  = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Enable;
    logic [1:0]   Speed;
    logic         Load;
    logic [W-1:0] LoadValue;
    logic         Wrap;
    logic         Tick;
    logic [W-1:0] CounterValue;
    logic         Done;

    always #5 Clock = ~Clock;

    rate_down_counter #(
        .CLOCK_FREQUENCY (CF),
        .WIDTH           (W)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Enable       (Enable),
        .Speed        (Speed),
        .Load         (Load),
        .LoadValue    (LoadValue),
        .Wrap         (Wrap),
        .Tick         (Tick),
        .CounterValue (CounterValue),
        .Done         (Done)
    );

    typedef struct packed {
        logic         tick;
        logic [W-1:0] cv;
        logic         done;
    } obs_t;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         wr;
        logic [W-1:0] cv;
        logic         done;
        logic         tick;
    } vec_t;

    obs_t exp_q[$];
    vec_t tbl[17];

    int n_vec     = 0;
    int n_bad     = 0;
    int tick_seen = 0;

    // Reference model state
    int m_rc;
    int m_cv;
    int m_sv;
    bit m_done;

    function automatic int per(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return CF;
            2'b10:   return 2 * CF;
            default: return 4 * CF;
        endcase
    endfunction

    function automatic bit m_tick();
        return (m_rc == 0) && (Enable == 1'b1) && (Load == 1'b0) && (Reset == 1'b0);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_rc   = per(Speed) - 1;
        m_cv   = 255;
        m_sv   = 255;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        bit t;
        t = m_tick();
        if (Load) begin
            m_rc = per(Speed) - 1;
            m_cv = int'(LoadValue);
            m_sv = int'(LoadValue);
        end else if (Enable) begin
            if (m_rc == 0) m_rc = per(Speed) - 1;
            else           m_rc = m_rc - 1;
        end
        if (!Load && t) begin
            if (m_cv > 0)  m_cv = m_cv - 1;
            else if (Wrap) m_cv = m_sv;
        end
        m_done = (m_cv == 0);
    endtask

    // One clock: drive inputs, predict on the edge, compare at the next negedge.
    task automatic cycle(input logic en, input logic [1:0] spd, input logic ld,
                         input logic [W-1:0] lv, input logic wr);
        obs_t e;
        obs_t a;
        Enable    = en;
        Speed     = spd;
        Load      = ld;
        LoadValue = lv;
        Wrap      = wr;
        @(posedge Clock);
        model_edge();
        e.tick = m_tick();
        e.cv   = W'(m_cv);
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge Clock);
        a = {Tick, CounterValue, Done};
        e = exp_q.pop_front();
        if (a.tick) tick_seen++;
        check("scoreboard", 32'(a), 32'(e));
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic reset_pulse();
        #1 Reset = 1'b1;
        #1;
        check("rst_cv",   32'(CounterValue), 32'hFF);
        check("rst_done", 32'(Done), 0);
        check("rst_tick", 32'(Tick), 0);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd3, 1'b0, 8'd2, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'd3, 1'b0, 8'd1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 8'd3, 1'b1, 8'd3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'd3, 1'b1, 8'd2, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'd3, 1'b1, 8'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'd3, 1'b1, 8'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'd3, 1'b1, 8'd3, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'd3, 1'b1, 8'd2, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 8'd5, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'd5, 1'b1, 8'd4, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1};

        Reset     = 1'b0;
        Enable    = 1'b1;
        Speed     = 2'b01;
        Load      = 1'b0;
        LoadValue = '0;
        Wrap      = 1'b0;

        // Reset and first periods at 1 Hz: Ticks on cycles 4, 8, 12.
        reset_pulse();
        tick_seen = 0;
        repeat (12) cycle(1'b1, 2'b01, 1'b0, 8'd0, 1'b0);
        check("hz1_ticks", tick_seen, 3);
        check("hz1_cv", 32'(CounterValue), 32'hFC);

        // Quarter rate: 16-cycle period once the running 1 Hz period ends.
        tick_seen = 0;
        repeat (40) cycle(1'b1, 2'b11, 1'b0, 8'd0, 1'b0);
        check("quarter_ticks", tick_seen, 3);

        // Switch to full rate mid-period: old period completes first.
        tick_seen = 0;
        repeat (30) cycle(1'b1, 2'b00, 1'b0, 8'd0, 1'b0);
        check("full_ticks", tick_seen, 20);

        // Enable stall mid-period at 1 Hz.
        repeat (2) cycle(1'b1, 2'b01, 1'b0, 8'd0, 1'b0);
        tick_seen = 0;
        repeat (10) cycle(1'b0, 2'b01, 1'b0, 8'd0, 1'b0);
        check("stall_ticks", tick_seen, 0);
        tick_seen = 0;
        repeat (8) cycle(1'b1, 2'b01, 1'b0, 8'd0, 1'b0);
        check("resume_ticks", tick_seen, 2);

        // Reset mid-count aborts; first Tick P cycles after release.
        reset_pulse();
        tick_seen = 0;
        repeat (4) cycle(1'b1, 2'b01, 1'b0, 8'd0, 1'b0);
        check("rst_mid_ticks", tick_seen, 1);
        check("rst_mid_cv", 32'(CounterValue), 32'hFE);

        // Reset at full rate with Enable high must still hold Tick low.
        cycle(1'b1, 2'b00, 1'b0, 8'd0, 1'b0);
        reset_pulse();

        // Load / wrap / hold-at-zero vectors at full rate.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 2'b00, tbl[i].ld, tbl[i].lv, tbl[i].wr);
            check($sformatf("vec%0d_cv", i),   32'(CounterValue), 32'(tbl[i].cv));
            check($sformatf("vec%0d_done", i), 32'(Done),         32'(tbl[i].done));
            check($sformatf("vec%0d_tick", i), 32'(Tick),         32'(tbl[i].tick));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
